// File: rtl/spi_master.sv
// SPI master for 8-bit frames, LSB first. SCLK idles low. MOSI changes on SCLK rising edges.
// MISO is sampled on SCLK falling edges. Each SCLK half-period lasts CLK_DIV clk cycles.
module spi_master #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] masterDataToSend,
    output logic [7:0] masterDataReceived,
    output logic       busy,
    output logic       done,
    output logic       SCLK,
    output logic       CS,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        TRANSFER,
        FINISH
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [3:0] edge_q, edge_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] data_rx_q, data_rx_d;
    logic       sclk_q, sclk_d;
    logic       cs_q, cs_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       mosi_q, mosi_d;
    logic       div_end;

    assign div_end = (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        edge_d    = edge_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        data_rx_d = data_rx_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mosi_d    = mosi_q;
        unique case (state_q)
            IDLE: begin
                div_d  = '0;
                edge_d = '0;
                if (start) begin
                    tx_d    = masterDataToSend;
                    rx_d    = '0;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = masterDataToSend[0];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_end) begin
                    div_d   = '0;
                    state_d = TRANSFER;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            TRANSFER: begin
                if (div_end) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        // Rising edge k presents bit k; the register shifts toward bit 0.
                        mosi_d = tx_q[0];
                        tx_d   = {1'b0, tx_q[7:1]};
                        edge_d = edge_q + 4'd1;
                    end else begin
                        rx_d = {MISO, rx_q[7:1]};
                        if (edge_q == 4'd15) begin
                            edge_d  = '0;
                            state_d = FINISH;
                        end else begin
                            edge_d = edge_q + 4'd1;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            FINISH: begin
                if (div_end) begin
                    div_d     = '0;
                    cs_d      = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    data_rx_d = rx_q;
                    mosi_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            edge_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            data_rx_q <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            data_rx_q <= data_rx_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mosi_q    <= mosi_d;
        end
    end

    assign masterDataReceived = data_rx_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign SCLK               = sclk_q;
    assign CS                 = cs_q;
    assign MOSI               = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: instance 0 uses CLK_DIV=2 and instance 1 uses CLK_DIV=1, both with a behavioural slave.
// A scoreboard holds the expected tx/rx of each frame, and a per-cycle monitor checks SCLK/CS behaviour.
module tb_spi_master;

    typedef struct {
        int         inst;
        logic [7:0] tx;
        logic [7:0] rx;
    } sb_t;

    typedef struct {
        int         inst;
        logic [7:0] tx;
        logic [7:0] slave;
        logic       loop;
        logic [7:0] exp_rx;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_s   [2];
    logic [7:0] tx_s      [2];
    logic [7:0] rx_w      [2];
    logic       busy_w    [2];
    logic       done_w    [2];
    logic       sclk_w    [2];
    logic       cs_w      [2];
    logic       mosi_w    [2];
    logic       miso_w    [2];
    logic [7:0] slave_byte[2];
    logic       loop_s    [2];
    logic [3:0] fall_cnt  [2];

    int         rise_cnt  [2];
    int         cs_cnt    [2];
    int         hi_run    [2];
    int         last_gap  [2];
    logic [7:0] mosi_cap  [2];
    logic       sclk_prev [2];
    logic       cs_prev   [2];
    logic       done_seen [2];

    sb_t        sb_q[$];
    vec_t       vecs[6];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            spi_master #(.CLK_DIV(gi == 0 ? 2 : 1)) u_dut (
                .clk               (clk),
                .reset             (reset),
                .start             (start_s[gi]),
                .masterDataToSend  (tx_s[gi]),
                .masterDataReceived(rx_w[gi]),
                .busy              (busy_w[gi]),
                .done              (done_w[gi]),
                .SCLK              (sclk_w[gi]),
                .CS                (cs_w[gi]),
                .MOSI              (mosi_w[gi]),
                .MISO              (miso_w[gi])
            );
            assign miso_w[gi] = loop_s[gi] ? mosi_w[gi] : slave_byte[gi][fall_cnt[gi][2:0]];
        end
    endgenerate

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor(input int i);
        sb_t e;
        int  div;
        div = (i == 0) ? 2 : 1;
        if (!reset) begin
            checks++;
            if ((cs_prev[i] && cs_w[i] && (sclk_w[i] != sclk_prev[i])) ||
                (sclk_prev[i] && sclk_w[i] && (cs_w[i] != cs_prev[i]))) begin
                errors++;
                $display("FAIL sclk_cs_rule inst=%0d: got cs %b->%b sclk %b->%b required no illegal change",
                         i, cs_prev[i], cs_w[i], sclk_prev[i], sclk_w[i]);
            end
        end
        if (cs_prev[i] && !cs_w[i]) begin
            last_gap[i] = hi_run[i];
            cs_cnt[i]   = 0;
            rise_cnt[i] = 0;
            fall_cnt[i] = '0;
            mosi_cap[i] = '0;
        end
        if (!cs_prev[i] && cs_w[i]) hi_run[i] = 0;
        if (cs_w[i]) hi_run[i]++;
        else cs_cnt[i]++;
        if (!sclk_prev[i] && sclk_w[i]) begin
            if (rise_cnt[i] < 8) mosi_cap[i][rise_cnt[i]] = mosi_w[i];
            rise_cnt[i]++;
        end
        if (sclk_prev[i] && !sclk_w[i]) fall_cnt[i] = fall_cnt[i] + 4'd1;
        if (done_w[i]) begin
            done_seen[i] = 1'b1;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done inst=%0d: got done=1 required no frame pending", i);
            end else begin
                e = sb_q.pop_front();
                $display("frame inst=%0d tx=%h rx=%h exp_rx=%h cs_low=%0d rises=%0d",
                         i, mosi_cap[i], rx_w[i], e.rx, cs_cnt[i], rise_cnt[i]);
                chk("frame_inst", 8'(i), 8'(e.inst));
                chk("rx_data", rx_w[i], e.rx);
                chk("mosi_bits", mosi_cap[i], e.tx);
                chk("sclk_rises", 8'(rise_cnt[i]), 8'd8);
                chk("cs_low_len", 8'(cs_cnt[i]), 8'(18 * div));
                chk("busy_at_done", {7'd0, busy_w[i]}, 8'd0);
            end
        end
        sclk_prev[i] = sclk_w[i];
        cs_prev[i]   = cs_w[i];
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) monitor(i);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send(input int i, input logic [7:0] tx, input logic [7:0] sl,
                        input logic lp, input logic [7:0] exp_rx);
        sb_t e;
        slave_byte[i] = sl;
        loop_s[i]     = lp;
        start_s[i]    = 1'b1;
        tx_s[i]       = tx;
        e.inst = i;
        e.tx   = tx;
        e.rx   = exp_rx;
        sb_q.push_back(e);
        tick();
        start_s[i] = 1'b0;
        tx_s[i]    = ~tx;
        chk("busy_after_start", {7'd0, busy_w[i]}, 8'd1);
    endtask

    task automatic wait_done(input int i, input int budget);
        done_seen[i] = 1'b0;
        for (int k = 0; k < budget && !done_seen[i]; k++) tick();
        checks++;
        if (!done_seen[i]) begin
            errors++;
            $display("FAIL done_timeout inst=%0d: got no done in %0d cycles required done", i, budget);
        end
    endtask

    initial begin
        vecs[0] = '{0, 8'h53, 8'h09, 1'b0, 8'h09};
        vecs[1] = '{0, 8'h00, 8'hFF, 1'b0, 8'hFF};
        vecs[2] = '{0, 8'hFF, 8'h00, 1'b0, 8'h00};
        vecs[3] = '{0, 8'hA7, 8'h00, 1'b1, 8'hA7};
        vecs[4] = '{1, 8'h81, 8'h00, 1'b1, 8'h81};
        vecs[5] = '{1, 8'h6E, 8'h35, 1'b0, 8'h35};

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; tx_s[i] = '0; slave_byte[i] = '0; loop_s[i] = 1'b0;
            fall_cnt[i] = '0; rise_cnt[i] = 0; cs_cnt[i] = 0; hi_run[i] = 0; last_gap[i] = 0;
            mosi_cap[i] = '0; sclk_prev[i] = 1'b0; cs_prev[i] = 1'b1; done_seen[i] = 1'b0;
        end
        ticks(3);
        for (int i = 0; i < 2; i++) begin
            chk("reset_cs", {7'd0, cs_w[i]}, 8'd1);
            chk("reset_sclk", {7'd0, sclk_w[i]}, 8'd0);
            chk("reset_mosi", {7'd0, mosi_w[i]}, 8'd0);
            chk("reset_busy", {7'd0, busy_w[i]}, 8'd0);
            chk("reset_done", {7'd0, done_w[i]}, 8'd0);
            chk("reset_rx", rx_w[i], 8'h00);
        end
        reset = 1'b0;
        ticks(2);

        for (int v = 0; v < 6; v++) begin
            send(vecs[v].inst, vecs[v].tx, vecs[v].slave, vecs[v].loop, vecs[v].exp_rx);
            wait_done(vecs[v].inst, 100);
            ticks(3);
            chk("rx_hold", rx_w[vecs[v].inst], vecs[v].exp_rx);
        end

        // Back-to-back frames: the second start lands in the done cycle of the first.
        send(0, 8'h3C, 8'h98, 1'b0, 8'h98);
        wait_done(0, 100);
        send(0, 8'hA5, 8'h5A, 1'b0, 8'h5A);
        ticks(10);
        chk("rx_hold_mid_frame", rx_w[0], 8'h98);
        wait_done(0, 100);
        chk("b2b_cs_gap", 8'(last_gap[0]), 8'd1);
        ticks(3);

        // A start pulse while busy must not disturb this frame or launch another.
        send(0, 8'hFF, 8'h3C, 1'b0, 8'h3C);
        ticks(9);
        start_s[0] = 1'b1;
        tx_s[0]    = 8'h00;
        tick();
        start_s[0] = 1'b0;
        wait_done(0, 100);
        ticks(40);
        chk("no_second_frame_cs", {7'd0, cs_w[0]}, 8'd1);
        chk("no_second_frame_busy", {7'd0, busy_w[0]}, 8'd0);

        // Reset after the 4th falling edge aborts the frame with no done.
        send(0, 8'h5A, 8'hC3, 1'b0, 8'hC3);
        for (int k = 0; k < 200 && fall_cnt[0] != 4'd4; k++) tick();
        chk("abort_reached_fall4", {4'd0, fall_cnt[0]}, 8'd4);
        reset = 1'b1;
        tick();
        chk("abort_cs", {7'd0, cs_w[0]}, 8'd1);
        chk("abort_sclk", {7'd0, sclk_w[0]}, 8'd0);
        chk("abort_busy", {7'd0, busy_w[0]}, 8'd0);
        chk("abort_done", {7'd0, done_w[0]}, 8'd0);
        chk("abort_rx", rx_w[0], 8'h00);
        reset = 1'b0;
        void'(sb_q.pop_back());
        ticks(60);

        send(0, 8'h96, 8'h69, 1'b0, 8'h69);
        wait_done(0, 100);
        ticks(3);
        chk("scoreboard_empty", 8'(sb_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 2: number of clk cycles per SCLK half-period; legal range 1..255.
REQ-002 clk  input  1  system clock; the block's only clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-004 start  input  1  request one 8-bit frame; sampled only while busy=0.
REQ-005 masterDataToSend  input  8  byte to transmit; captured in the cycle start is accepted.
REQ-006 masterDataReceived  output  8  last complete byte received on MISO.
REQ-007 busy  output  1  high from the cycle after start is accepted until the cycle CS returns high.
REQ-008 done  output  1  one-clk pulse marking frame completion.
REQ-009 SCLK  output  1  serial clock to slave; idles low.
REQ-010 CS  output  1  active-low slave select; idles high.
REQ-011 MOSI  output  1  serial data to slave.
REQ-012 MISO  input  1  serial data from slave.

Function
REQ-013 The FSM SHALL have the states IDLE, SETUP, TRANSFER and FINISH, each with a divider counter and a 4-bit edge counter.
REQ-014 IDLE: on start=1, latch masterDataToSend into tx shift register, clear rx register, CS<=0, busy<=1, go to SETUP; when start=0, remain in IDLE.
REQ-015 SETUP: SCLK held low for CLK_DIV cycles, MOSI<=tx[0] on entry, then go to TRANSFER.
REQ-016 TRANSFER: SCLK toggles every CLK_DIV cycles; exactly 8 rising and 8 falling edges per frame.
REQ-017 Data order SHALL be LSB first: on SCLK rising edge k (k=0..7), MOSI<=tx[k].
REQ-018 On each SCLK falling edge, rx<={MISO, rx[7:1]}, sampling the MISO value present in that clk cycle.
REQ-019 After the 8th falling edge, go to FINISH with SCLK low.
REQ-020 FINISH: hold CS low, SCLK low for CLK_DIV cycles; then CS<=1, busy<=0, done<=1 for one cycle, masterDataReceived<=rx, MOSI<=0, go to IDLE.
REQ-021 Frame length, CS low to CS high, SHALL be exactly 18*CLK_DIV clk cycles.
REQ-022 start while busy=1 SHALL be ignored, with no effect on the frame in progress or on a later frame.
REQ-023 start in the cycle done=1 SHALL be accepted (back-to-back frames); CS high for exactly 1 cycle between them.
REQ-024 masterDataToSend changes after acceptance SHALL NOT affect the frame in progress.
REQ-025 masterDataReceived SHALL change only on frame completion and hold otherwise.
REQ-026 SCLK SHALL never toggle while CS=1; CS SHALL never change while SCLK=1.

Reset
REQ-027 On reset: state<=IDLE, SCLK=0, CS=1, MOSI=0, busy=0, done=0, masterDataReceived=8'h00, counters and shift registers cleared.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no done pulse; outputs reach REQ-027 values one clk edge later.
REQ-029 reset has priority over start in the same cycle.

Verification
REQ-030 CLK_DIV=2, send 8'h53, slave model returns 8'h09 -> MOSI bits 1,1,0,0,1,0,1,0 on rising edges; masterDataReceived=8'h09; done pulse; CS low 36 cycles.
REQ-031 Send 8'h3C, slave returns 8'h98, then start in done cycle with 8'hA5/8'h5A -> received 8'h98 then 8'h5A; CS high 1 cycle between frames.
REQ-032 start pulsed at cycle 10 of an 8'hFF frame with masterDataToSend=8'h00 -> frame completes sending 8'hFF, no second frame starts.
REQ-033 reset asserted after 4th SCLK falling edge -> next cycle CS=1, SCLK=0, busy=0, masterDataReceived=8'h00, no done.
REQ-034 CLK_DIV=1, send 8'h81 loopback (MISO tied to MOSI) -> masterDataReceived=8'h81, frame 18 cycles.
REQ-035 All scenarios: assertion checks REQ-026 every cycle and counts exactly 8 SCLK rising edges per frame.
